// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl
// Purpose  : Read-side controller for a direct-mapped instruction cache with
//            one word per line. It looks up fetch requests, returns hits
//            directly, and fills misses from memory before returning the word.
// Ports    : clk, reset (async, active low)
//            req_valid/req_ready/req_addr         - fetch request handshake
//            resp_valid/resp_data/resp_hit        - one-cycle response pulse
//            mem_req_valid/ready/addr             - fill request to memory
//            mem_resp_valid/mem_resp_data         - fill data from memory
//            flush                                - invalidate all lines
//            hit_count/miss_count                 - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_COMPARE  = 3'd1;
    localparam logic [2:0] S_MEM_REQ  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_RESPOND  = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid [NUM_LINES];
    logic [TAG_W-1:0]      r_tag   [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_data  [NUM_LINES];
    logic                  r_flush_pending;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_cmp_hit;
    logic [DATA_WIDTH-1:0] w_lookup_data;
    logic                  w_fill_we;
    logic                  w_flush_clr;
    logic                  w_accept;

    // Lookup always uses the registered address, so the index/tag seen in
    // COMPARE and in MEM_WAIT (line write) refer to the same request.
    assign w_idx         = r_addr[2 +: IDX_W];
    assign w_tag         = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_cmp_hit     = (r_state == S_COMPARE) && w_hit;
    assign w_lookup_data = r_data[w_idx];
    assign w_fill_we     = (r_state == S_MEM_WAIT) && mem_resp_valid;
    // A flush seen outside IDLE is deferred; the invalidate happens on the
    // first IDLE cycle, which is also why no request is accepted then.
    assign w_flush_clr   = (r_state == S_IDLE) && (flush || r_flush_pending);
    assign req_ready     = (r_state == S_IDLE) && !r_flush_pending && !flush;
    assign w_accept      = req_valid && req_ready;

    // Line storage: valid bits are reset, tag/data are plain enabled flops.
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_valid[g] <= 1'b0;
            end else if (w_flush_clr) begin
                r_valid[g] <= 1'b0;
            end else if (w_fill_we && (w_idx == IDX_W'(g))) begin
                r_valid[g] <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_fill_we && (w_idx == IDX_W'(g))) begin
                r_tag[g]  <= w_tag;
                r_data[g] <= mem_resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_flush_pending <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_fill_data     <= '0;
            r_resp_data     <= '0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_flush_clr) begin
                        r_flush_pending <= 1'b0;
                    end
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_resp_data <= w_lookup_data;
                        if (r_hit_cnt != '1) begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= {r_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_state         <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        r_fill_data <= mem_resp_data;
                        r_state     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_resp_data <= r_fill_data;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (flush && (r_state != S_IDLE)) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    // The response is driven straight from the lookup/fill registers so a hit
    // is visible in the COMPARE cycle; r_resp_data keeps the last word shown.
    assign resp_valid    = w_cmp_hit || (r_state == S_RESPOND);
    assign resp_hit      = w_cmp_hit;
    assign resp_data     = w_cmp_hit                ? w_lookup_data :
                           (r_state == S_RESPOND)   ? r_fill_data   :
                                                      r_resp_data;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign hit_count     = r_hit_cnt;
    assign miss_count    = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fill_ctrl
// Purpose  : Directed self-checking bench for icache_fill_ctrl. A second
//            instance with 2-bit counters shares all stimulus so counter
//            saturation can be observed alongside the normal instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        flush;

    logic        req_ready, resp_valid, resp_hit, mem_req_valid;
    logic [31:0] resp_data, mem_req_addr;
    logic [15:0] hit_count, miss_count;

    logic        req_ready_s, resp_valid_s, resp_hit_s, mem_req_valid_s;
    logic [31:0] resp_data_s, mem_req_addr_s;
    logic [1:0]  hit_count_s, miss_count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl #(.CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_fill_ctrl #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_addr(req_addr),
        .resp_valid(resp_valid_s), .resp_data(resp_data_s), .resp_hit(resp_hit_s),
        .mem_req_valid(mem_req_valid_s), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr_s), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .flush(flush),
        .hit_count(hit_count_s), .miss_count(miss_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch starting from an IDLE cycle (1 ns after a rising edge).
    // rdy_dly: cycles memory holds ready low; rsp_dly: idle cycles in MEM_WAIT
    // before data; flush_wait pulses flush in the first MEM_WAIT cycle.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] data,
                         input int rdy_dly, input int rsp_dly, input bit flush_wait);
        logic [31:0] exp_maddr;
        exp_maddr = {addr[31:2], 2'b00};
        req_valid = 1'b1;
        req_addr  = addr;
        check("req_ready", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0;
        if (exp_hit) begin
            check("hit_valid", {31'd0, resp_valid}, 32'd1);
            check("hit_flag", {31'd0, resp_hit}, 32'd1);
            check("hit_data", resp_data, data);
            check("hit_no_memreq", {31'd0, mem_req_valid}, 32'd0);
            tick;
            check("hit_pulse_end", {31'd0, resp_valid}, 32'd0);
        end else begin
            check("miss_no_resp", {31'd0, resp_valid}, 32'd0);
            tick;
            for (int i = 0; i < rdy_dly; i++) begin
                check("memreq_hold_valid", {31'd0, mem_req_valid}, 32'd1);
                check("memreq_hold_addr", mem_req_addr, exp_maddr);
                tick;
            end
            check("memreq_valid", {31'd0, mem_req_valid}, 32'd1);
            check("memreq_addr", mem_req_addr, exp_maddr);
            mem_req_ready = 1'b1;
            tick;
            mem_req_ready = 1'b0;
            check("memreq_drop", {31'd0, mem_req_valid}, 32'd0);
            for (int i = 0; i < rsp_dly; i++) begin
                if (flush_wait && i == 0) flush = 1'b1;
                tick;
                flush = 1'b0;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = data;
            tick;
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            check("fill_valid", {31'd0, resp_valid}, 32'd1);
            check("fill_flag", {31'd0, resp_hit}, 32'd0);
            check("fill_data", resp_data, data);
            tick;
            check("fill_pulse_end", {31'd0, resp_valid}, 32'd0);
            check("fill_data_held", resp_data, data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        flush          = 1'b0;
        tick;
        tick;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_memreq_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_memreq_addr", mem_req_addr, 32'h0);
        check("rst_hits", {16'd0, hit_count}, 32'd0);
        check("rst_misses", {16'd0, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // Cold miss: ready after 2 cycles, data after 3 more.
        fetch(32'h0000_1004, 1'b0, 32'hDEAD_BEEF, 2, 3, 1'b0);
        check("cold_misses", {16'd0, miss_count}, 32'd1);
        check("cold_hits", {16'd0, hit_count}, 32'd0);

        // Stray memory response in IDLE must be ignored.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h5555_AAAA;
        tick;
        mem_resp_valid = 1'b0;
        check("stray_no_resp", {31'd0, resp_valid}, 32'd0);
        check("stray_ready", {31'd0, req_ready}, 32'd1);

        // Hit on the same address.
        fetch(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
        check("hit_hits", {16'd0, hit_count}, 32'd1);
        check("hit_misses", {16'd0, miss_count}, 32'd1);

        // Conflict on index 1 evicts the first line.
        fetch(32'h0000_2004, 1'b0, 32'h1234_5678, 1, 1, 1'b0);
        fetch(32'h0000_1004, 1'b0, 32'hDEAD_BEEF, 0, 2, 1'b0);
        check("conflict_misses", {16'd0, miss_count}, 32'd3);
        check("conflict_sat_misses", {30'd0, miss_count_s}, 32'd3);

        // Flush during MEM_WAIT: response still delivered, then one blocked IDLE cycle.
        fetch(32'h0000_2004, 1'b0, 32'hAAAA_5555, 0, 2, 1'b1);
        check("flush_blocked", {31'd0, req_ready}, 32'd0);
        tick;
        check("flush_unblocked", {31'd0, req_ready}, 32'd1);
        fetch(32'h0000_2004, 1'b0, 32'hAAAA_5555, 0, 0, 1'b0);
        check("flush_misses", {16'd0, miss_count}, 32'd5);
        check("flush_sat_misses", {30'd0, miss_count_s}, 32'd3);
        check("flush_hits", {16'd0, hit_count}, 32'd1);

        // Reset in MEM_REQ.
        req_valid = 1'b1;
        req_addr  = 32'h0000_3008;
        tick;
        req_valid = 1'b0;
        tick;
        check("rstmid_memreq_up", {31'd0, mem_req_valid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid_memreq_drop", {31'd0, mem_req_valid}, 32'd0);
        check("rstmid_hits", {16'd0, hit_count}, 32'd0);
        check("rstmid_misses", {16'd0, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        // Previously filled line must be gone; ready arrives on entry cycle.
        fetch(32'h0000_2004, 1'b0, 32'hCAFE_0001, 0, 0, 1'b0);
        check("post_rst_misses", {16'd0, miss_count}, 32'd1);

        // Five hits: 16-bit counter reads 5, 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            fetch(32'h0000_2004, 1'b1, 32'hCAFE_0001, 0, 0, 1'b0);
        end
        check("sat_hits_wide", {16'd0, hit_count}, 32'd5);
        check("sat_hits_narrow", {30'd0, hit_count_s}, 32'd3);
        check("sat_misses_narrow", {30'd0, miss_count_s}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
